// File: rtl/pc_stack.sv
// pc_stack: shift-register return-address stack for a PIC10F200-class core; stk[0] is TOS.
// Optional macro PC_STACK_WRAP_EN: push while full discards the oldest entry (PIC behaviour) instead of being ignored.
module pc_stack #(
    parameter int DEPTH = 2,
    parameter int AW    = 9,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    input  logic          clr_flags,
    output logic [AW-1:0] tos,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

`ifdef PC_STACK_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic [AW-1:0] stk     [DEPTH];
    logic [AW-1:0] stk_nxt [DEPTH];
    logic [LW-1:0] level_nxt;
    logic          ovf_set;
    logic          unf_set;

    assign tos   = stk[0];
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // Simultaneous push+pop only replaces TOS, so it never raises a flag.
    assign ovf_set = push && !pop && full;
    assign unf_set = pop && !push && empty;

    always_comb begin
        stk_nxt   = stk;
        level_nxt = level;
        unique case ({push, pop})
            2'b11: stk_nxt[0] = push_data;
            2'b10: begin
                if (!full || WRAP_EN) begin
                    for (int i = 1; i < DEPTH; i++) stk_nxt[i] = stk[i-1];
                    stk_nxt[0] = push_data;
                end
                if (!full) level_nxt = level + LW'(1);
            end
            2'b01: begin
                // Bottom entry is left in place, so it gets duplicated upward.
                for (int i = 0; i < DEPTH - 1; i++) stk_nxt[i] = stk[i+1];
                if (!empty) level_nxt = level - LW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            stk   <= stk_nxt;
            level <= level_nxt;
            // A set event in the same cycle beats clr_flags.
            ovf   <= ovf_set | (ovf & ~clr_flags);
            unf   <= unf_set | (unf & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Randomized + directed bench for pc_stack against a list-based behavioural model.
module tb_pc_stack;
    localparam int DEPTH = 2;
    localparam int AW    = 9;
    localparam int LW    = $clog2(DEPTH + 1);
`ifdef PC_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0, push = 1'b0, pop = 1'b0, clr_flags = 1'b0;
    logic [AW-1:0] push_data = '0;
    logic [AW-1:0] tos;
    logic [LW-1:0] level;
    logic          empty, full, ovf, unf;

    int checks = 0;
    int errors = 0;

    // Model: m_stk[0] is the newest entry; m_lvl counts valid entries.
    logic [AW-1:0] m_stk [DEPTH];
    int            m_lvl = 0;
    bit            m_ovf = 0, m_unf = 0;
    bit            chk_en = 0;

    pc_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
        .clr_flags(clr_flags), .tos(tos), .level(level), .empty(empty),
        .full(full), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit pu, input bit po,
                              input logic [AW-1:0] d, input bit c);
        bit os, us;
        if (r) begin
            foreach (m_stk[i]) m_stk[i] = '0;
            m_lvl = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        os = pu && !po && (m_lvl == DEPTH);
        us = po && !pu && (m_lvl == 0);
        if (pu && po) begin
            m_stk[0] = d;
        end else if (pu) begin
            if (m_lvl < DEPTH || WRAP) begin
                for (int i = DEPTH - 1; i > 0; i--) m_stk[i] = m_stk[i-1];
                m_stk[0] = d;
            end
            if (m_lvl < DEPTH) m_lvl++;
        end else if (po) begin
            for (int i = 0; i < DEPTH - 1; i++) m_stk[i] = m_stk[i+1];
            if (m_lvl > 0) m_lvl--;
        end
        m_ovf = os || (m_ovf && !c);
        m_unf = us || (m_unf && !c);
    endtask

    task automatic step(input bit r, input bit pu, input bit po,
                        input logic [AW-1:0] d, input bit c);
        @(negedge clk);
        rst = r; push = pu; pop = po; push_data = d; clr_flags = c;
        @(posedge clk);
        model_step(r, pu, po, d, c);
        if (r) chk_en = 1;
        #1;
    endtask

    // Every cycle once the model is seeded by a reset.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tos",   int'(tos),   int'(m_stk[0]));
            chk("level", int'(level), m_lvl);
            chk("empty", int'(empty), int'(m_lvl == 0));
            chk("full",  int'(full),  int'(m_lvl == DEPTH));
            chk("ovf",   int'(ovf),   int'(m_ovf));
            chk("unf",   int'(unf),   int'(m_unf));
        end
    end

    initial begin
        // Random activity before the first reset.
        repeat (5) step(0, 1'($urandom), 1'($urandom), AW'($urandom), 0);
        step(1, 1, 0, 9'h0AA, 0);
        chk("rst_tos", int'(tos), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_flags", int'({ovf, unf}), 0);

        // Push/pop order with bottom duplication.
        step(0, 1, 0, 9'h012, 0);
        step(0, 1, 0, 9'h1A5, 0);
        chk("push2_tos", int'(tos), 'h1A5);
        chk("push2_level", int'(level), 2);
        chk("push2_full", int'(full), 1);
        step(0, 0, 1, 9'h000, 0);
        chk("pop1_tos", int'(tos), 'h012);
        chk("pop1_level", int'(level), 1);
        step(0, 0, 1, 9'h000, 0);
        chk("pop2_level", int'(level), 0);
        chk("pop2_empty", int'(empty), 1);
        chk("pop2_tos", int'(tos), 'h012);

        // Overflow from 0x1A5/0x012.
        step(0, 1, 0, 9'h012, 0);
        step(0, 1, 0, 9'h1A5, 0);
        step(0, 1, 0, 9'h0FF, 0);
        chk("ovf_tos", int'(tos), WRAP ? 'h0FF : 'h1A5);
        chk("ovf_level", int'(level), 2);
        chk("ovf_flag", int'(ovf), 1);
        step(0, 0, 1, 9'h000, 0);
        chk("ovf_next", int'(tos), WRAP ? 'h1A5 : 'h012);

        // Underflow and flag priority.
        step(1, 0, 0, 9'h000, 0);
        step(0, 0, 1, 9'h000, 0);
        chk("unf_level", int'(level), 0);
        chk("unf_flag", int'(unf), 1);
        step(0, 0, 0, 9'h000, 1);
        chk("unf_clr", int'(unf), 0);
        step(0, 0, 1, 9'h000, 1);
        chk("unf_set_wins", int'(unf), 1);

        // Simultaneous push+pop at level 1.
        step(0, 0, 0, 9'h000, 1);
        step(0, 1, 0, 9'h040, 0);
        step(0, 1, 1, 9'h155, 0);
        chk("pp_tos", int'(tos), 'h155);
        chk("pp_level", int'(level), 1);
        chk("pp_flags", int'({ovf, unf}), 0);

        // Push coincident with reset is dropped.
        step(1, 1, 0, 9'h0AA, 0);
        chk("rstpush_tos", int'(tos), 0);
        chk("rstpush_level", int'(level), 0);

        // Randomized traffic, occasional reset.
        for (int n = 0; n < 3000; n++)
            step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
                 AW'($urandom), ($urandom_range(0, 7) == 0));

        step(1, 0, 0, 9'h000, 0);
        chk("final_rst_level", int'(level), 0);
        chk("final_rst_tos", int'(tos), 0);
        @(negedge clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_stack.md
# pc_stack

Hardware return-address stack for the PIC10F200-class core. It captures the program counter value on CALL and hands it back to the program counter's load-mux input on RETLW. It is the consumer/supplier at the other end of the PC's 9-bit address path. The default depth is 2 levels, matching the PIC10F200. Depth is a parameter so larger baseline parts can reuse the block.

## Interface
- `DEPTH`, 2: number of stack levels; legal range 2–8.
- `AW`, 9: address width; must equal the PC width.
- `clk`  in  1  instruction-cycle clock, rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `push`  in  1  CALL: push `push_data` this cycle.
- `pop`  in  1  RETLW: pop this cycle.
- `push_data`  in  AW  return address to save; driven from the PC output.
- `clr_flags`  in  1  clears sticky `ovf`/`unf`.
- `tos`  out  AW  top-of-stack; feeds the PC load mux.
- `level`  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- `empty`  out  1  `level == 0`.
- `full`  out  1  `level == DEPTH`.
- `ovf`  out  1  sticky: a push occurred while full.
- `unf`  out  1  sticky: a pop occurred while empty.

## Operation
- Storage is a shift-register array `stk[0..DEPTH-1]`, with `stk[0]` as TOS. `tos = stk[0]`, combinational from the registers.
- **Push only:**
  - `stk[i] <= stk[i-1]` for i≥1, and `stk[0] <= push_data`.
  - `level` increments, saturating at DEPTH.
- **Pop only:**
  - `stk[i] <= stk[i+1]` for i<DEPTH-1.
  - `stk[DEPTH-1]` keeps its value; the bottom entry is duplicated, per PIC behaviour.
  - `level` decrements, saturating at 0.
- **Push and pop in the same cycle:**
  - `stk[0] <= push_data`; all other entries and `level` are unchanged.
  - Flags are unchanged, including when empty or full.
- **Pop while empty:**
  - The array still shifts as in pop-only.
  - `level` stays 0 and `unf` sets.
- **Push while full:** behaviour depends on the Configuration macro. `ovf` sets in both builds.
- **Flag priority:** `clr_flags` clears `ovf`/`unf`. A set event in the same cycle wins over `clr_flags`.
- Neither `push` nor `pop` asserted: all state holds.
- `rst` has priority over every other input.

## Timing
- **Reset** (on the first `clk` edge with `rst`=1):
  - All `stk` entries = 0, `tos` = 0, `level` = 0.
  - `empty` = 1, `full` = 0, `ovf` = 0, `unf` = 0.
- **Push latency:** `push_data` sampled at edge N appears on `tos` immediately after edge N. The PC may load it on edge N+1 at the earliest.
- **Pop latency:** after the pop edge, `tos` shows the next entry.
  - The PC must load `tos` in the same cycle `pop` is asserted. It therefore captures the pre-pop TOS on the same edge as the pop.
- **Single-cycle operations:** no handshake, no stall, no back-pressure. Every request is completed on the edge it is sampled.
- **Status outputs:** `level`, `empty`, `full`, `ovf` and `unf` are registered or derived from registers. They are valid one edge after the causing operation.
- **Reset mid-operation:** a `push` or `pop` coincident with `rst` is discarded.

## Configuration
- **Macro:** `PC_STACK_WRAP_EN`.
- **Defined (PIC-compatible build):**
  - A push while full shifts normally; the oldest entry `stk[DEPTH-1]` is lost.
  - `level` stays at DEPTH and `ovf` sets.
- **Undefined (protected build):**
  - A push while full is ignored; the array and `level` are unchanged.
  - `ovf` sets.
  - Simultaneous push+pop while full still replaces TOS.

## Test plan
- **Reset:** assert `rst` for 1 cycle after random activity → `tos`=0, `level`=0, `empty`=1, `full`=0, `ovf`=`unf`=0.
- **Push/pop order:** push 0x012, then push 0x1A5 → `tos`=0x1A5, `level`=2, `full`=1. Pop → `tos`=0x012, `level`=1. Pop → `level`=0, `empty`=1, `tos`=0x012 (bottom duplicated).
- **Overflow:** with the stack at 0x1A5/0x012, push 0x0FF.
  - WRAP_EN build → `tos`=0x0FF, `stk[1]`=0x1A5, `level`=2, `ovf`=1.
  - Non-WRAP build → `tos`=0x1A5 unchanged, `ovf`=1.
- **Underflow:** pop on an empty stack → `level`=0, `unf`=1. Then `clr_flags` → `unf`=0. `clr_flags` coincident with another empty pop → `unf` stays 1.
- **Simultaneous push+pop:** at `level`=1 with TOS 0x040, assert push (0x155) and pop together → `tos`=0x155, `level`=1, flags unchanged.
- **Reset during operation:** `rst` asserted together with push 0x0AA → `tos`=0, `level`=0; the push is not retained.
